// File: rtl/led_pwm_port.sv
// Bus-mapped 8-channel LED PWM: enable mask, shadowed per-LED duty, programmable prescaler.
// Every access completes with a one-cycle ready pulse the cycle after the strobe; no stalls.
module led_pwm_port #(
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_RESET = 97
) (
    input  logic                  clk_25mhz,
    input  logic                  reset_n,
    input  logic [3:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic [7:0]            led
);

    localparam logic [3:0] ADDR_EN    = 4'h0;
    localparam logic [3:0] ADDR_DUTY0 = 4'h1;
    localparam logic [3:0] ADDR_DUTY7 = 4'h8;
    localparam logic [3:0] ADDR_PRESC = 4'h9;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic [7:0]            led_en_q, led_en_d;
    logic [7:0][7:0]       duty_sh_q, duty_sh_d;
    logic [7:0][7:0]       duty_act_q, duty_act_d;
    logic [15:0]           prescale_q, prescale_d;
    logic [15:0]           presc_cnt_q, presc_cnt_d;
    logic [7:0]            phase_q, phase_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [7:0]            led_q, led_d;

    logic                  is_duty;
    logic [2:0]            duty_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  tick;
    logic                  frame_wrap;
    logic                  wdata_unused;

    assign is_duty      = (addr >= ADDR_DUTY0) && (addr <= ADDR_DUTY7);
    assign duty_idx     = 3'(addr - ADDR_DUTY0);
    assign wdata_unused = ^wdata[DATA_WIDTH-1:16];

    always_comb begin
        rd_val = '0;
        if (addr == ADDR_EN) begin
            rd_val[7:0] = led_en_q;
        end else if (is_duty) begin
            rd_val[7:0] = duty_sh_q[duty_idx];
        end else if (addr == ADDR_PRESC) begin
            rd_val[15:0] = prescale_q;
        end
    end

    // Register writes and bus response; a simultaneous we+re is treated as a write.
    always_comb begin
        led_en_d   = led_en_q;
        duty_sh_d  = duty_sh_q;
        prescale_d = prescale_q;
        if (we) begin
            if (addr == ADDR_EN) begin
                led_en_d = wdata[7:0];
            end else if (is_duty) begin
                duty_sh_d[duty_idx] = wdata[7:0];
            end else if (addr == ADDR_PRESC) begin
                prescale_d = wdata[15:0];
            end
        end
        ready_d = we | re;
        rdata_d = (re && !we) ? rd_val : '0;
    end

    // Counter compares for equality only, so a prescale written below the
    // running count lets it run through 0xFFFF and wrap before ticking.
    always_comb begin
        tick        = (presc_cnt_q == prescale_q);
        frame_wrap  = tick && (phase_q == 8'hFF);
        presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
        phase_d     = tick ? phase_q + 8'd1 : phase_q;
        duty_act_d  = frame_wrap ? duty_sh_q : duty_act_q;
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < 8; i++) begin
            led_d[i] = led_en_q[i] &
                       ((duty_act_q[i] == 8'hFF) | (phase_q < duty_act_q[i]));
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_int_n) begin
        if (!rst_int_n) begin
            led_en_q    <= '0;
            duty_sh_q   <= '0;
            duty_act_q  <= '0;
            prescale_q  <= 16'(PRESCALE_RESET);
            presc_cnt_q <= '0;
            phase_q     <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            led_q       <= '0;
        end else begin
            led_en_q    <= led_en_d;
            duty_sh_q   <= duty_sh_d;
            duty_act_q  <= duty_act_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            phase_q     <= phase_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            led_q       <= led_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign led   = led_q;

endmodule
